dmi_auth_gate: RTL and testbench
================================

// Module: dmi_auth_gate
// PURPOSE
// - Parametrised DMI access gate between the JTAG DMI CDC (core side) and the debug module, in the clk_i domain.
// - Authenticates a multi-word password via an external HMAC engine and forwards DMI writes only while unlocked.
// - Forwards reads while locked only if policy permits.
// - Adds bounded retry with timed lockout, idle auto-relock and a per-request deny response.
// PARAMETERS
// - PassWords      4         number of 32-bit DTM_PASS words forming one password message
// - HashWidth      256       width of hash_i / exp_hash_i
// - MaxAttempts    3         consecutive failed checks before lockout (>=1)
// - LockoutCycles  1024      lockout duration in clk_i cycles; 0 = permanent until reset
// - RelockCycles   65536     idle cycles (no accepted request) before auto-relock; 0 = never
// PORTS
// - clk_i            in   1            DMI clock
// - rst_i            in   1            asynchronous reset, active-high
// - req_i            in   dmi_req_t    upstream request {addr, data, op}
// - req_valid_i      in   1            upstream request valid
// - req_ready_o      out  1            upstream request ready
// - resp_o           out  dmi_resp_t   upstream response {data, resp}
// - resp_valid_o     out  1            upstream response valid
// - resp_ready_i     in   1            upstream response ready
// - dm_req_o         out  dmi_req_t    downstream request
// - dm_req_valid_o   out  1            downstream request valid
// - dm_req_ready_i   in   1            downstream request ready
// - dm_resp_i        in   dmi_resp_t   downstream response
// - dm_resp_valid_i  in   1            downstream response valid
// - dm_resp_ready_o  out  1            downstream response ready
// - read_allow_i     in   1            1 = reads forwarded while locked
// - exp_hash_i       in   HashWidth    expected password hash
// - hash_start_o     out  1            one-cycle pulse starting the HMAC
// - hash_msg_o       out  512          zero-extended {word[PassWords-1],...,word[0]}
// - hash_ready_i     in   1            HMAC idle
// - hash_valid_i     in   1            hash_i valid
// - hash_i           in   HashWidth    computed hash
// - unlock_o         out  1            gate unlocked
// - lockout_o        out  1            lockout active
// - fail_cnt_o       out  $clog2(MaxAttempts+1)   consecutive failure count
// BEHAVIOUR
// - Reset values: all valid/start outputs = 0; unlock_o = 0; lockout_o = 0; fail_cnt_o = 0.
// - Reset values: state = Idle; word index = 0; password buffer = 0.
// - Reset mid-operation aborts silently; no response is issued.
// - One request in flight. req_ready_o = 1 only in Idle and never while a response is pending.
// - Request accept cycle routes the request:
//   - READ, when unlock_o or read_allow_i: go to Fwd.
//   - WRITE, when unlock_o: go to Fwd.
//   - PASS, when !lockout_o: store data in word[idx], then idx++.
//     - idx reaches PassWords: go to HashStart, idx = 0.
//     - Otherwise: go to Resp with resp = 0, data = 0.
//   - NOP: go to Resp with resp = 0.
//   - Anything else: go to Resp with resp = 2 (denied), data = 0; no downstream traffic.
// - Fwd: dm_req_valid_o held until dm_req_ready_i, then go to WaitResp.
// - WaitResp: dm_resp_ready_o = 1; on dm_resp_valid_i capture dm_resp_i and go to Resp.
// - HashStart: wait for hash_ready_i, then pulse hash_start_o for 1 cycle and go to HashWait.
// - HashWait: on hash_valid_i compare hash_i against exp_hash_i.
//   - Match: unlock_o = 1, fail_cnt = 0, resp = 0.
//   - Mismatch: unlock_o = 0, fail_cnt++ (saturating), resp = 2.
//     - If fail_cnt reaches MaxAttempts: lockout_o = 1, load the lockout counter.
//   - Either outcome: go to Resp.
// - Resp: resp_valid_o held until resp_ready_i, then go to Idle. Response latency is at least 1 cycle after accept.
// - Lockout: counter decrements every cycle. At 0: lockout_o = 0, fail_cnt = 0. Never expires when LockoutCycles = 0.
// - Lockout does not clear an existing unlock. A PASS arriving during lockout is denied and idx is left unchanged.
// - Relock: idle counter reloads on every accepted request.
//   - On expiry: unlock_o = 0 and idx = 0.
//   - If expiry coincides with a request accept, the accept wins (counter reloads, no relock).
// - A successful PASS while already unlocked keeps unlock_o = 1. A failed one clears it.
// - Password buffer is cleared to 0 after every hash comparison.
// STRUCTURE
// - Put in dm_pkg: dtm_op_e including DTM_PASS, dmi_resp code constants (0 = OK, 2 = FAILED), auth_state_e.
// - One sub-module, dmi_auth_timer: a loadable down-counter with expire pulse, instantiated twice (lockout, relock).
// TESTING
// - Locked WRITE addr 0x10, data 0xDEAD -> resp = 2, dm_req_valid_o stays 0.
// - 4 PASS words matching -> exactly one hash_start_o, unlock_o = 1; then WRITE is forwarded with the same addr/data.
// - 3 wrong passwords -> fail_cnt_o = 3, lockout_o = 1; correct PASS during lockout -> resp = 2, no hash_start_o.
// - LockoutCycles = 16: lockout_o falls exactly 16 cycles after the third failure; a correct password then unlocks.
// - RelockCycles = 8: unlock, idle 8 cycles -> unlock_o = 0; a request on cycle 8 keeps it unlocked.
// - read_allow_i = 1 while locked: READ is forwarded; dm_req_ready_i low for 5 cycles stalls with no upstream response; rst_i mid-HashWait -> all outputs reset.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared DMI types, response codes and gate FSM states.
package dm_pkg;

  localparam int unsigned AddrWidth = 7;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned MsgWidth  = 512;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'd0,
    DTM_READ  = 2'd1,
    DTM_WRITE = 2'd2,
    DTM_PASS  = 2'd3
  } dtm_op_e;

  localparam logic [1:0] DmiRespOk     = 2'd0;
  localparam logic [1:0] DmiRespFailed = 2'd2;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] data;
    dtm_op_e              op;
  } dmi_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
  } dmi_resp_t;

  typedef enum logic [2:0] {
    StIdle,
    StFwd,
    StWaitResp,
    StHashStart,
    StHashWait,
    StResp
  } auth_state_e;

endpackage

// File: rtl/dmi_auth_gate_if.sv
// DMI request/response handshake bundle; master issues requests, slave answers.
interface dmi_auth_gate_if;
  import dm_pkg::*;

  dmi_req_t  req;
  logic      req_valid;
  logic      req_ready;
  dmi_resp_t resp;
  logic      resp_valid;
  logic      resp_ready;

  modport master (
    output req, req_valid, resp_ready,
    input  req_ready, resp, resp_valid
  );

  modport slave (
    input  req, req_valid, resp_ready,
    output req_ready, resp, resp_valid
  );

endinterface

// File: rtl/dmi_auth_timer.sv
// Loadable down-counter; expire pulses on the enabled cycle that takes it from 1 to 0.
// A load value of 0 leaves the timer idle, so it never expires.
module dmi_auth_timer #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Load has priority over counting so a reload suppresses a coinciding expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign expire = en && !load && (cnt_q == Width'(1));

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmi_auth_gate.sv
// DMI access gate: password authentication via external HMAC, lockout and idle relock.
module dmi_auth_gate
  import dm_pkg::*;
#(
  parameter int unsigned PassWords     = 4,
  parameter int unsigned HashWidth     = 256,
  parameter int unsigned MaxAttempts   = 3,
  parameter int unsigned LockoutCycles = 1024,
  parameter int unsigned RelockCycles  = 65536
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  dmi_auth_gate_if.slave                   up,
  dmi_auth_gate_if.master                  dm,
  input  logic                             read_allow_i,
  input  logic [HashWidth-1:0]             exp_hash_i,
  output logic                             hash_start_o,
  output logic [MsgWidth-1:0]              hash_msg_o,
  input  logic                             hash_ready_i,
  input  logic                             hash_valid_i,
  input  logic [HashWidth-1:0]             hash_i,
  output logic                             unlock_o,
  output logic                             lockout_o,
  output logic [$clog2(MaxAttempts+1)-1:0] fail_cnt_o
);

  localparam int unsigned FailWidth = $clog2(MaxAttempts + 1);
  localparam int unsigned IdxWidth  = $clog2(PassWords + 1);
  localparam int unsigned BufWidth  = PassWords * DataWidth;
  localparam logic [FailWidth-1:0] FailMax = FailWidth'(MaxAttempts);
  localparam logic [IdxWidth-1:0]  LastIdx = IdxWidth'(PassWords - 1);

  auth_state_e          state_q, state_d;
  dmi_req_t             req_q, req_d;
  dmi_resp_t            resp_q, resp_d;
  logic [BufWidth-1:0]  buf_q, buf_d;
  logic [IdxWidth-1:0]  idx_q, idx_d;
  logic                 unlock_q, unlock_d;
  logic                 lockout_q, lockout_d;
  logic [FailWidth-1:0] fail_q, fail_d;

  logic accept, hash_done, hash_match;
  logic lock_load, lock_expire;
  logic relock_load, relock_en, relock_expire;

  assign accept      = (state_q == StIdle) && up.req_valid;
  assign hash_done   = (state_q == StHashWait) && hash_valid_i;
  assign hash_match  = hash_done && (hash_i == exp_hash_i);
  // Lockout starts on the mismatch that brings the failure count to its limit.
  assign lock_load   = hash_done && !hash_match && (fail_q == FailMax - 1'b1);
  assign relock_load = accept || hash_match;
  assign relock_en   = unlock_q && (state_q == StIdle);

  dmi_auth_timer #(
    .Width(32)
  ) u_lockout_timer (
    .clk     (clk_i),
    .rst     (rst_i),
    .load    (lock_load),
    .load_val(32'(LockoutCycles)),
    .en      (lockout_q),
    .expire  (lock_expire)
  );

  dmi_auth_timer #(
    .Width(32)
  ) u_relock_timer (
    .clk     (clk_i),
    .rst     (rst_i),
    .load    (relock_load),
    .load_val(32'(RelockCycles)),
    .en      (relock_en),
    .expire  (relock_expire)
  );

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: captured request/response, password buffer and auth status.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q     <= '0;
      resp_q    <= '0;
      buf_q     <= '0;
      idx_q     <= '0;
      unlock_q  <= 1'b0;
      lockout_q <= 1'b0;
      fail_q    <= '0;
    end else begin
      req_q     <= req_d;
      resp_q    <= resp_d;
      buf_q     <= buf_d;
      idx_q     <= idx_d;
      unlock_q  <= unlock_d;
      lockout_q <= lockout_d;
      fail_q    <= fail_d;
    end
  end

  // Next state: request routing, hash evaluation and timer effects.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    resp_d    = resp_q;
    buf_d     = buf_q;
    idx_d     = idx_q;
    unlock_d  = unlock_q;
    lockout_d = lockout_q;
    fail_d    = fail_q;
    unique case (state_q)
      StIdle: begin
        if (up.req_valid) begin
          // Default outcome is a deny; permitted operations override it.
          req_d       = up.req;
          resp_d      = '0;
          resp_d.resp = DmiRespFailed;
          state_d     = StResp;
          unique case (up.req.op)
            DTM_READ:  if (unlock_q || read_allow_i) state_d = StFwd;
            DTM_WRITE: if (unlock_q) state_d = StFwd;
            DTM_PASS: begin
              if (!lockout_q) begin
                buf_d[idx_q*DataWidth +: DataWidth] = up.req.data;
                resp_d.resp = DmiRespOk;
                if (idx_q == LastIdx) begin
                  idx_d   = '0;
                  state_d = StHashStart;
                end else begin
                  idx_d = idx_q + 1'b1;
                end
              end
            end
            DTM_NOP:   resp_d.resp = DmiRespOk;
            default:   ;
          endcase
        end
      end
      StFwd: begin
        if (dm.req_ready) state_d = StWaitResp;
      end
      StWaitResp: begin
        if (dm.resp_valid) begin
          resp_d  = dm.resp;
          state_d = StResp;
        end
      end
      StHashStart: begin
        if (hash_ready_i) state_d = StHashWait;
      end
      StHashWait: begin
        if (hash_done) begin
          buf_d  = '0;
          resp_d = '0;
          if (hash_match) begin
            unlock_d = 1'b1;
            fail_d   = '0;
          end else begin
            unlock_d    = 1'b0;
            resp_d.resp = DmiRespFailed;
            if (fail_q != FailMax) fail_d = fail_q + 1'b1;
            if (lock_load) lockout_d = 1'b1;
          end
          state_d = StResp;
        end
      end
      StResp: begin
        if (up.resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (lock_expire) begin
      lockout_d = 1'b0;
      fail_d    = '0;
    end
    if (relock_expire) begin
      unlock_d = 1'b0;
      idx_d    = '0;
    end
  end

  // Outputs decoded from state and registered datapath.
  always_comb begin
    up.req_ready  = (state_q == StIdle);
    up.resp_valid = (state_q == StResp);
    up.resp       = resp_q;
    dm.req        = req_q;
    dm.req_valid  = (state_q == StFwd);
    dm.resp_ready = (state_q == StWaitResp);
    hash_start_o  = (state_q == StHashStart) && hash_ready_i;
    hash_msg_o    = '0;
    hash_msg_o[BufWidth-1:0] = buf_q;
    unlock_o      = unlock_q;
    lockout_o     = lockout_q;
    fail_cnt_o    = fail_q;
  end

endmodule

// File: tb/tb_dmi_auth_gate.sv
// Directed bench for dmi_auth_gate with a response scoreboard and an inline DM/HMAC model.
module tb_dmi_auth_gate;
  import dm_pkg::*;

  localparam logic [127:0] GoodPw = 128'h4444_0004_3333_0003_2222_0002_1111_0001;
  localparam logic [127:0] BadPw  = 128'h4444_0004_3333_0003_2222_0002_1111_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         read_allow, hash_ready, hash_valid, hash_start, unlock, lockout;
  logic [255:0] exp_hash, hash;
  logic [511:0] hash_msg;
  logic [1:0]   fail_cnt;
  logic [127:0] cur_pw;

  int compared = 0, mismatched = 0;
  int hs_cnt = 0, fwd_cyc = 0, lock_run = 0, last_run = 0;
  dmi_resp_t exp_q[$];

  dmi_auth_gate_if up_if ();
  dmi_auth_gate_if dm_if ();

  dmi_auth_gate #(
    .PassWords(4), .HashWidth(256), .MaxAttempts(3), .LockoutCycles(16), .RelockCycles(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .up(up_if), .dm(dm_if),
    .read_allow_i(read_allow), .exp_hash_i(exp_hash),
    .hash_start_o(hash_start), .hash_msg_o(hash_msg), .hash_ready_i(hash_ready),
    .hash_valid_i(hash_valid), .hash_i(hash),
    .unlock_o(unlock), .lockout_o(lockout), .fail_cnt_o(fail_cnt)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Event monitors: hash start pulses, downstream valid cycles, lockout run length.
  always @(negedge clk) begin
    if (hash_start) hs_cnt <= hs_cnt + 1;
    if (dm_if.req_valid) fwd_cyc <= fwd_cyc + 1;
    if (lockout) lock_run <= lock_run + 1;
    else if (lock_run != 0) begin
      last_run <= lock_run;
      lock_run <= 0;
    end
  end

  function automatic logic [31:0] dm_data(input logic [6:0] a);
    return 32'h5A00_0000 | {25'd0, a};
  endfunction

  function automatic logic [255:0] hmac(input logic [511:0] m);
    return m[255:0] ^ {8{32'h9E37_79B9}};
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input dtm_op_e op, input logic [6:0] addr, input logic [31:0] data,
                        input bit fwd, input int stall, input bit hashing, input logic [1:0] code);
    dmi_resp_t exp_r, got;
    dmi_req_t  exp_req;
    logic [511:0] msg;
    int n, hs0, fwd0;
    hs0 = hs_cnt;
    fwd0 = fwd_cyc;
    exp_r.data = fwd ? dm_data(addr) : 32'h0;
    exp_r.resp = fwd ? DmiRespOk : code;
    exp_q.push_back(exp_r);
    exp_req = '{addr: addr, data: data, op: op};
    @(negedge clk);
    up_if.req = exp_req;
    up_if.req_valid = 1'b1;
    n = 0;
    while (!up_if.req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_accept", up_if.req_ready, 1'b1);
    @(negedge clk);
    up_if.req_valid = 1'b0;
    if (fwd) begin
      n = 0;
      while (!dm_if.req_valid && n < 20) begin @(negedge clk); n++; end
      check("dm_req_fields", {dm_if.req_valid, dm_if.req}, {1'b1, exp_req});
      for (int s = 0; s < stall; s++) begin
        check("stall_no_resp", {dm_if.req_valid, up_if.resp_valid}, 2'b10);
        @(negedge clk);
      end
      dm_if.req_ready = 1'b1;
      @(negedge clk);
      dm_if.req_ready = 1'b0;
      check("dm_resp_ready", dm_if.resp_ready, 1'b1);
      dm_if.resp = '{data: dm_data(addr), resp: DmiRespOk};
      dm_if.resp_valid = 1'b1;
      @(negedge clk);
      dm_if.resp_valid = 1'b0;
    end
    if (hashing) begin
      n = 0;
      while (!hash_start && n < 20) begin @(negedge clk); n++; end
      check("hash_start", hash_start, 1'b1);
      msg = hash_msg;
      check("hash_msg", msg, {384'd0, cur_pw});
      repeat (2) @(negedge clk);
      hash = hmac(msg);
      hash_valid = 1'b1;
      @(negedge clk);
      hash_valid = 1'b0;
    end
    n = 0;
    while (!up_if.resp_valid && n < 50) begin @(negedge clk); n++; end
    check("resp_valid", up_if.resp_valid, 1'b1);
    up_if.resp_ready = 1'b1;
    got = up_if.resp;
    check("resp", got, exp_q.pop_front());
    @(negedge clk);
    up_if.resp_ready = 1'b0;
    check("hash_start_count", hs_cnt - hs0, hashing ? 1 : 0);
    check("dm_traffic", fwd_cyc != fwd0, fwd);
  endtask

  task automatic send_pass(input logic [127:0] pw, input bit good);
    cur_pw = pw;
    for (int i = 0; i < 4; i++) begin
      do_req(DTM_PASS, 7'h00, pw[i*32 +: 32], 1'b0, 0, i == 3,
             (i == 3 && !good) ? DmiRespFailed : DmiRespOk);
    end
  endtask

  initial begin
    int n;
    up_if.req = '0; up_if.req_valid = 1'b0; up_if.resp_ready = 1'b0;
    dm_if.req_ready = 1'b0; dm_if.resp = '0; dm_if.resp_valid = 1'b0;
    read_allow = 1'b0; hash_ready = 1'b1; hash_valid = 1'b0; hash = '0;
    exp_hash = hmac({384'd0, GoodPw});
    cur_pw = GoodPw;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_status", {unlock, lockout, fail_cnt}, 4'b0);
    check("rst_valids", {up_if.resp_valid, dm_if.req_valid, hash_start, up_if.req_ready}, 4'b0001);
    check("rst_msg", hash_msg, 512'd0);
    rst = 1'b0;

    // Locked write is denied without downstream traffic.
    do_req(DTM_WRITE, 7'h10, 32'h0000_DEAD, 1'b0, 0, 1'b0, DmiRespFailed);

    // Correct password unlocks; write then forwarded unchanged.
    send_pass(GoodPw, 1'b1);
    check("unlock_after_good", unlock, 1'b1);
    do_req(DTM_WRITE, 7'h22, 32'hCAFE_F00D, 1'b1, 0, 1'b0, DmiRespOk);

    // Idle relock after exactly 8 idle cycles.
    check("relock_before", unlock, 1'b1);
    repeat (7) @(negedge clk);
    check("relock_cycle7", unlock, 1'b1);
    @(negedge clk);
    check("relock_cycle8", unlock, 1'b0);

    // A request accepted on the 8th idle cycle keeps the gate unlocked.
    send_pass(GoodPw, 1'b1);
    repeat (6) @(negedge clk);
    do_req(DTM_NOP, 7'h00, 32'h0, 1'b0, 0, 1'b0, DmiRespOk);
    check("relock_accept_wins", unlock, 1'b1);

    // Three wrong passwords cause lockout; a failure also drops an existing unlock.
    send_pass(BadPw, 1'b0);
    check("fail1", {unlock, lockout, fail_cnt}, 4'b0001);
    send_pass(BadPw, 1'b0);
    check("fail2", fail_cnt, 2'd2);
    send_pass(BadPw, 1'b0);
    check("fail3", {unlock, lockout, fail_cnt}, 4'b0111);
    do_req(DTM_PASS, 7'h00, GoodPw[31:0], 1'b0, 0, 1'b0, DmiRespFailed);
    n = 0;
    while (lockout && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    check("lockout_len", last_run, 16);
    check("lockout_clear", {lockout, fail_cnt}, 3'b000);
    send_pass(GoodPw, 1'b1);
    check("unlock_after_lockout", unlock, 1'b1);

    // Reads while locked: forwarded only with read_allow, stall gives no upstream response.
    repeat (10) @(negedge clk);
    check("relocked", unlock, 1'b0);
    read_allow = 1'b1;
    do_req(DTM_READ, 7'h05, 32'h0, 1'b1, 5, 1'b0, DmiRespOk);
    read_allow = 1'b0;
    do_req(DTM_READ, 7'h06, 32'h0, 1'b0, 0, 1'b0, DmiRespFailed);

    // Reset during HashWait aborts everything.
    send_pass(BadPw, 1'b0);
    cur_pw = GoodPw;
    for (int i = 0; i < 3; i++)
      do_req(DTM_PASS, 7'h00, GoodPw[i*32 +: 32], 1'b0, 0, 1'b0, DmiRespOk);
    @(negedge clk);
    up_if.req = '{addr: 7'h00, data: GoodPw[127:96], op: DTM_PASS};
    up_if.req_valid = 1'b1;
    n = 0;
    while (!up_if.req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    up_if.req_valid = 1'b0;
    n = 0;
    while (!hash_start && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    check("pre_rst_state", {hash_msg != 512'd0, fail_cnt}, 3'b101);
    rst = 1'b1;
    #1;
    check("mid_rst_status", {unlock, lockout, fail_cnt}, 4'b0);
    check("mid_rst_valids", {up_if.resp_valid, dm_if.req_valid, hash_start, up_if.req_ready},
          4'b0001);
    check("mid_rst_msg", hash_msg, 512'd0);
    @(negedge clk);
    rst = 1'b0;
    do_req(DTM_NOP, 7'h00, 32'h0, 1'b0, 0, 1'b0, DmiRespOk);
    check("post_rst_status", {unlock, lockout, fail_cnt}, 4'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
